// File: rtl/uart_aid_arbiter.sv
// UART access-ID arbiter: in-order request queue with owner grant/release.
// Optional ownership timeout is built when UART_AID_TIMEOUT_EN is defined.
module uart_aid_arbiter #(
  parameter int AID_FIFO_SIZE = 8,
  parameter int ID_WIDTH      = 8,
  parameter int TMO_WIDTH     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  input  logic                                   req_valid_i,
  input  logic [ID_WIDTH-1:0]                    req_id_i,
  output logic                                   req_ready_o,
  input  logic                                   rel_valid_i,
  input  logic [ID_WIDTH-1:0]                    rel_id_i,
  input  logic                                   flush_i,
  input  logic [TMO_WIDTH-1:0]                   tmo_limit_i,
  output logic                                   owner_valid_o,
  output logic [ID_WIDTH-1:0]                    owner_id_o,
  output logic [$clog2(AID_FIFO_SIZE+1)-1:0]     q_count_o,
  output logic                                   dup_o,
  output logic                                   rel_err_o,
  output logic                                   tmo_o
);

  localparam int IDX_W = $clog2(AID_FIFO_SIZE);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(AID_FIFO_SIZE + 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ID_WIDTH-1:0]   mem_q [AID_FIFO_SIZE];
  logic                  owner_valid_q;
  logic [ID_WIDTH-1:0]   owner_id_q;
  logic                  dup_q, rel_err_q;

  logic [PTR_W-1:0]      count;
  logic                  full, empty;
  logic [IDX_W-1:0]      slot_off;
  logic                  q_match, dup_hit, push, rel_match, tmo_hit;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // A slot holds a live entry when its distance from the read index is below the count.
  always_comb begin
    q_match  = 1'b0;
    slot_off = '0;
    for (int i = 0; i < AID_FIFO_SIZE; i++) begin
      slot_off = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
      if (({1'b0, slot_off} < count) && (mem_q[i] == req_id_i)) q_match = 1'b1;
    end
  end

  assign dup_hit   = q_match || (owner_valid_q && (req_id_i == owner_id_q));
  assign push      = req_valid_i && !full && !dup_hit && !flush_i;
  assign rel_match = rel_valid_i && (state_q == OWNED) && (rel_id_i == owner_id_q);

`ifdef UART_AID_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_cnt_q;
  logic                 tmo_q;

  assign tmo_hit = (state_q == OWNED) && (tmo_limit_i != '0) &&
                   (tmo_cnt_q == tmo_limit_i - TMO_WIDTH'(1));
  assign tmo_o   = tmo_q;
`else
  logic unused_tmo_limit;

  assign unused_tmo_limit = ^tmo_limit_i;
  assign tmo_hit          = 1'b0;
  assign tmo_o            = 1'b0;
`endif

  // Queue storage carries data only, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= req_id_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
      dup_q         <= 1'b0;
      rel_err_q     <= 1'b0;
`ifdef UART_AID_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      tmo_q         <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      owner_valid_q <= 1'b0;
      dup_q         <= 1'b0;
      rel_err_q     <= 1'b0;
`ifdef UART_AID_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      tmo_q         <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      dup_q     <= req_valid_i && !full && dup_hit;
      rel_err_q <= rel_valid_i && !rel_match;
`ifdef UART_AID_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!empty) begin
            owner_id_q    <= mem_q[rd_ptr_q[IDX_W-1:0]];
            owner_valid_q <= 1'b1;
            rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
            state_q       <= OWNED;
`ifdef UART_AID_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
          end
        end
        OWNED: begin
          // A matching release takes precedence over a coincident timeout.
          if (rel_match || tmo_hit) begin
            owner_valid_q <= 1'b0;
            state_q       <= IDLE;
`ifdef UART_AID_TIMEOUT_EN
            tmo_q         <= !rel_match;
            tmo_cnt_q     <= '0;
`endif
          end
`ifdef UART_AID_TIMEOUT_EN
          else if ((tmo_limit_i != '0) && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = !full;
  assign owner_valid_o = owner_valid_q;
  assign owner_id_o    = owner_id_q;
  assign q_count_o     = CNT_W'(count);
  assign dup_o         = dup_q;
  assign rel_err_o     = rel_err_q;

endmodule

// File: tb/tb_uart_aid_arbiter.sv
// Directed bench for uart_aid_arbiter; expected values are hand-computed per step.
module tb_uart_aid_arbiter;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       req_valid_i;
  logic [7:0] req_id_i;
  logic       req_ready_o;
  logic       rel_valid_i;
  logic [7:0] rel_id_i;
  logic       flush_i;
  logic [15:0] tmo_limit_i;
  logic       owner_valid_o;
  logic [7:0] owner_id_o;
  logic [3:0] q_count_o;
  logic       dup_o;
  logic       rel_err_o;
  logic       tmo_o;

  int checks = 0;
  int errors = 0;

  uart_aid_arbiter #(.AID_FIFO_SIZE(8), .ID_WIDTH(8), .TMO_WIDTH(16)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .req_valid_i(req_valid_i), .req_id_i(req_id_i), .req_ready_o(req_ready_o),
    .rel_valid_i(rel_valid_i), .rel_id_i(rel_id_i),
    .flush_i(flush_i), .tmo_limit_i(tmo_limit_i),
    .owner_valid_o(owner_valid_o), .owner_id_o(owner_id_o), .q_count_o(q_count_o),
    .dup_o(dup_o), .rel_err_o(rel_err_o), .tmo_o(tmo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_i = 1'b1; req_valid_i = 1'b0; req_id_i = 8'h00; rel_valid_i = 1'b0;
    rel_id_i = 8'h00; flush_i = 1'b0; tmo_limit_i = 16'd0;
    #12;
    chk("rst_owner_valid", owner_valid_o, 0);
    chk("rst_owner_id", owner_id_o, 0);
    chk("rst_q_count", q_count_o, 0);
    chk("rst_pulses", {dup_o, rel_err_o, tmo_o}, 0);
    arst_i = 1'b0;

    // First grant into an empty arbiter
    req_valid_i = 1'b1; req_id_i = 8'h11;
    tick();
    req_valid_i = 1'b0;
    chk("t1_count_after_write", q_count_o, 1);
    chk("t1_not_yet_owned", owner_valid_o, 0);
    tick();
    chk("t1_owner_valid", owner_valid_o, 1);
    chk("t1_owner_id", owner_id_o, 8'h11);
    chk("t1_count_drained", q_count_o, 0);

    // In-order handoff 0x11 -> 0x22 -> 0x33
    req_valid_i = 1'b1; req_id_i = 8'h22; tick();
    req_id_i = 8'h33; tick();
    req_valid_i = 1'b0;
    chk("t2_count2", q_count_o, 2);
    rel_valid_i = 1'b1; rel_id_i = 8'h11; tick();
    rel_valid_i = 1'b0;
    chk("t2_idle_gap", owner_valid_o, 0);
    chk("t2_no_relerr", rel_err_o, 0);
    tick();
    chk("t2_owner22_valid", owner_valid_o, 1);
    chk("t2_owner22_id", owner_id_o, 8'h22);
    chk("t2_count1", q_count_o, 1);
    rel_valid_i = 1'b1; rel_id_i = 8'h22; tick();
    rel_valid_i = 1'b0;
    chk("t2_idle_gap2", owner_valid_o, 0);
    tick();
    chk("t2_owner33_id", owner_id_o, 8'h33);
    chk("t2_count0", q_count_o, 0);

    // Ignored releases
    rel_valid_i = 1'b1; rel_id_i = 8'h44; tick();
    rel_valid_i = 1'b0;
    chk("t3_relerr_wrong_id", rel_err_o, 1);
    chk("t3_owner_kept", {owner_valid_o, owner_id_o}, {1'b1, 8'h33});
    tick();
    chk("t3_relerr_oneshot", rel_err_o, 0);
    rel_valid_i = 1'b1; rel_id_i = 8'h33; tick();
    rel_valid_i = 1'b0;
    chk("t3_released", owner_valid_o, 0);
    tick();
    rel_valid_i = 1'b1; rel_id_i = 8'h55; tick();
    rel_valid_i = 1'b0;
    chk("t3_relerr_idle", rel_err_o, 1);
    chk("t3_idle_stays", owner_valid_o, 0);
    chk("t3_owner_id_holds", owner_id_o, 8'h33);

    // Duplicates, then fill the queue
    req_valid_i = 1'b1; req_id_i = 8'h11; tick();
    req_valid_i = 1'b0; tick();
    chk("t4_owner11", {owner_valid_o, owner_id_o}, {1'b1, 8'h11});
    req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_id_i = 8'hA0 + 8'(i); tick();
    end
    chk("t4_count3", q_count_o, 3);
    req_id_i = 8'h11; tick();
    chk("t4_dup_owner", dup_o, 1);
    chk("t4_dup_owner_count", q_count_o, 3);
    req_id_i = 8'hA1; tick();
    chk("t4_dup_queued", dup_o, 1);
    chk("t4_dup_queued_count", q_count_o, 3);
    for (int i = 3; i < 8; i++) begin
      req_id_i = 8'hA0 + 8'(i); tick();
    end
    chk("t4_no_dup_fill", dup_o, 0);
    chk("t4_count8", q_count_o, 8);
    chk("t4_not_ready", req_ready_o, 0);
    req_id_i = 8'hB0; tick();
    req_valid_i = 1'b0;
    chk("t4_ninth_dropped", q_count_o, 8);
    chk("t4_full_no_dup", dup_o, 0);

    // Flush with an owner and a full queue, plus a concurrent request
    flush_i = 1'b1; req_valid_i = 1'b1; req_id_i = 8'hC0; rel_valid_i = 1'b1; rel_id_i = 8'h99;
    tick();
    flush_i = 1'b0; req_valid_i = 1'b0; rel_valid_i = 1'b0;
    chk("t5_flush_count", q_count_o, 0);
    chk("t5_flush_owner", owner_valid_o, 0);
    chk("t5_flush_pulses", {dup_o, rel_err_o, tmo_o}, 0);
    chk("t5_flush_ready", req_ready_o, 1);
    tick();
    chk("t5_flush_req_lost", {owner_valid_o, q_count_o}, 0);

    // Release and request of the releasing ID in one cycle
    req_valid_i = 1'b1; req_id_i = 8'h11; tick();
    req_valid_i = 1'b0; tick();
    chk("t6_owner11", {owner_valid_o, owner_id_o}, {1'b1, 8'h11});
    req_valid_i = 1'b1; rel_valid_i = 1'b1; rel_id_i = 8'h11; tick();
    req_valid_i = 1'b0; rel_valid_i = 1'b0;
    chk("t6_dup", dup_o, 1);
    chk("t6_released", owner_valid_o, 0);
    chk("t6_count", q_count_o, 0);
    tick();
    chk("t6_no_regrant", owner_valid_o, 0);

    // Ownership timeout with limit 5
    tmo_limit_i = 16'd5;
    req_valid_i = 1'b1; req_id_i = 8'h11; tick();
    req_id_i = 8'h22; tick();
    req_valid_i = 1'b0;
    chk("t7_granted", {owner_valid_o, owner_id_o, q_count_o}, {1'b1, 8'h11, 4'd1});
    for (int i = 0; i < 4; i++) tick();
    chk("t7_held_4", {owner_valid_o, tmo_o}, {1'b1, 1'b0});
    tick();
`ifdef UART_AID_TIMEOUT_EN
    chk("t7_tmo_pulse", tmo_o, 1);
    chk("t7_revoked", owner_valid_o, 0);
    tick();
    chk("t7_tmo_oneshot", tmo_o, 0);
    chk("t7_next_owner", {owner_valid_o, owner_id_o}, {1'b1, 8'h22});
`else
    chk("t7_no_tmo", tmo_o, 0);
    chk("t7_still_owned", {owner_valid_o, owner_id_o}, {1'b1, 8'h11});
    tick();
    chk("t7_still_owned2", {owner_valid_o, owner_id_o, q_count_o}, {1'b1, 8'h11, 4'd1});
`endif

    // Asynchronous reset mid-operation
    req_valid_i = 1'b1; req_id_i = 8'h66; tick();
    req_valid_i = 1'b0;
    #2 arst_i = 1'b1;
    #1;
    chk("t8_async_owner", owner_valid_o, 0);
    chk("t8_async_count", q_count_o, 0);
    chk("t8_async_id", owner_id_o, 0);
    arst_i = 1'b0;
    tick();
    chk("t8_queue_lost", {owner_valid_o, q_count_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
